// File: rtl/averager_pkg.sv
// Shared types and sizing helpers for the averager buffer readout path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package averager_pkg;

    // Readout FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // One stream beat as stored in the skid FIFO.
    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    localparam int DEFAULT_READ_LATENCY = 2;

    // The skid FIFO must absorb every read in flight plus two more entries
    // so the issue rule can keep one word per cycle flowing.
    localparam int FIFO_DEPTH = DEFAULT_READ_LATENCY + 2;

    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    // n_avg carries the frame count in the bits left over above the
    // buffer address width.
    function automatic int navg_w(input int width);
        return 32 - width;
    endfunction

endpackage

// File: rtl/averager_reader_fifo.sv
// Small synchronous skid FIFO; head entry is a flop that drives dat_o directly.
// Latency: 1 cycle push-to-vld_o; count updates on the same edge.
// Backpressure: pop_i is ignored while empty; push_i must never hit a full FIFO.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i/_dat_i write strobe and word
//   pop_i         consume head entry (when vld_o)
//   vld_o, dat_o  head valid and head word (registered)
//   cnt_o         number of stored entries
module averager_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic                       vld_o,
    output logic [W-1:0]               dat_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     ent_q [DEPTH];
    logic [W-1:0]     ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wr_idx;
    logic             vld_q, vld_d;
    logic             do_pop;

    // Shift-register organisation: entry 0 is always the head, so the
    // output is a plain flop and stays put while the consumer stalls.
    always_comb begin
        ent_d  = ent_q;
        cnt_d  = cnt_q;
        wr_idx = cnt_q;
        do_pop = pop_i && vld_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i + 1];
            end
            ent_d[DEPTH - 1] = '0;
            wr_idx = cnt_q - CNT_W'(1);
        end
        if (push_i && (int'(wr_idx) < DEPTH)) begin
            ent_d[wr_idx[IDX_W-1:0]] = push_dat_i;
        end
        cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
        vld_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = ent_q[0];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/averager_reader.sv
// Streams the averager accumulation buffer out over AXI4-Stream after each frame.
// Latency: trigger at T -> first read T+1, first tvalid T+2+READ_LATENCY (+1 with shift stage).
// Backpressure: reads are throttled so the skid FIFO never overflows; stalls delay, never drop.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ready, n_avg    averager frame-complete pulse (edge detected) and frame count
//   bram_*          BRAM port-B read: byte address, enable, data (READ_LATENCY later)
//   shift           arithmetic right shift, only with AVERAGER_READER_SHIFT_EN
//   m_axis_*        output stream, tlast on word 2^WIDTH-1
//   n_avg_out       n_avg captured at trigger
//   busy, missed    readout in progress; saturating count of ignored triggers
//
// Build option: define AVERAGER_READER_SHIFT_EN to insert a registered
// arithmetic-shift stage between BRAM and FIFO.
module averager_reader
    import averager_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    input  logic [navg_w(WIDTH)-1:0] n_avg,
    output logic [WIDTH+1:0]         bram_addr,
    input  logic [31:0]              bram_rdata,
    output logic                     bram_en,
    input  logic [4:0]               shift,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [navg_w(WIDTH)-1:0] n_avg_out,
    output logic                     busy,
    output logic [15:0]              missed
);

`ifdef AVERAGER_READER_SHIFT_EN
    localparam int EFF_LAT = READ_LATENCY + 1;
`else
    localparam int EFF_LAT = READ_LATENCY;
`endif
    localparam int DEPTH = fifo_depth(EFF_LAT);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NW    = navg_w(WIDTH);

    rd_state_e               state_q, state_d;
    logic [WIDTH-1:0]        idx_q, idx_d;
    logic [NW-1:0]           navg_q, navg_d;
    logic [15:0]             missed_q, missed_d;
    logic                    ready_q;
    logic                    trig;

    // One valid/last bit per read still travelling through the BRAM.
    logic [READ_LATENCY-1:0] pvld_q;
    logic [READ_LATENCY-1:0] plast_q;

    logic                    issue;
    logic                    frame_done;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_vld;
    beat_t                   push_beat;
    logic                    push;
    beat_t                   head_beat;

    assign trig = ready && !ready_q;

`ifdef AVERAGER_READER_SHIFT_EN
    logic        sh_vld_q;
    logic        sh_last_q;
    logic [31:0] sh_dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vld_q  <= 1'b0;
            sh_last_q <= 1'b0;
            sh_dat_q  <= '0;
        end else begin
            sh_vld_q  <= pvld_q[READ_LATENCY-1];
            sh_last_q <= plast_q[READ_LATENCY-1];
            if (pvld_q[READ_LATENCY-1]) begin
                sh_dat_q <= $signed(bram_rdata) >>> shift;
            end
        end
    end

    assign push           = sh_vld_q;
    assign push_beat.data = sh_dat_q;
    assign push_beat.last = sh_last_q;
`else
    logic shift_unused;
    assign shift_unused   = ^shift;

    assign push           = pvld_q[READ_LATENCY-1];
    assign push_beat.data = bram_rdata;
    assign push_beat.last = plast_q[READ_LATENCY-1];
`endif

    // Reads issued but not yet in the FIFO, including the shift stage.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pvld_q[i]);
        end
`ifdef AVERAGER_READER_SHIFT_EN
        inflight = inflight + CNT_W'(sh_vld_q);
`endif
    end

    // Every issued read already owns a FIFO slot, so data returning after
    // any length of stall always has somewhere to land.
    assign issue = (state_q == READ) &&
                   (({1'b0, fifo_cnt} + {1'b0, inflight}) < (CNT_W+1)'(DEPTH));

    // The tlast beat is the last thing in the pipe, so its handshake means
    // the FIFO is empty afterwards.
    assign frame_done = fifo_vld && m_axis_tready && head_beat.last && (inflight == '0);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        navg_d   = navg_q;
        missed_d = missed_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = READ;
                    idx_d   = '0;
                    navg_d  = n_avg;
                end
            end
            READ: begin
                if (issue) begin
                    idx_d = idx_q + WIDTH'(1);
                    if (idx_q == '1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (trig && (state_q != IDLE) && (missed_q != 16'hFFFF)) begin
            missed_d = missed_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            navg_q   <= '0;
            missed_q <= '0;
            ready_q  <= 1'b0;
            pvld_q   <= '0;
            plast_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            navg_q     <= navg_d;
            missed_q   <= missed_d;
            ready_q    <= ready;
            pvld_q[0]  <= issue;
            plast_q[0] <= issue && (idx_q == '1);
            for (int i = 1; i < READ_LATENCY; i++) begin
                pvld_q[i]  <= pvld_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end
        end
    end

    averager_reader_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(beat_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_beat),
        .pop_i      (m_axis_tready),
        .vld_o      (fifo_vld),
        .dat_o      (head_beat),
        .cnt_o      (fifo_cnt)
    );

    assign bram_addr     = {idx_q, 2'b00};
    assign bram_en       = issue;
    assign m_axis_tvalid = fifo_vld;
    assign m_axis_tdata  = head_beat.data;
    assign m_axis_tlast  = head_beat.last;
    assign n_avg_out     = navg_q;
    assign busy          = (state_q != IDLE);
    assign missed        = missed_q;

endmodule

// File: tb/tb_averager_reader.sv
// Directed bench for averager_reader with WIDTH=4, READ_LATENCY=2 and a
// two-cycle BRAM model. Honours AVERAGER_READER_SHIFT_EN when defined.
module tb_averager_reader;

`ifdef AVERAGER_READER_SHIFT_EN
    localparam int FIRST = 5;
    localparam int DEPTH = 5;
`else
    localparam int FIRST = 4;
    localparam int DEPTH = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [27:0] n_avg;
    logic [5:0]  bram_addr;
    logic [31:0] bram_rdata;
    logic        bram_en;
    logic [4:0]  shift;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [27:0] n_avg_out;
    logic        busy;
    logic [15:0] missed;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    averager_reader #(.WIDTH(4), .READ_LATENCY(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .n_avg         (n_avg),
        .bram_addr     (bram_addr),
        .bram_rdata    (bram_rdata),
        .bram_en       (bram_en),
        .shift         (shift),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .n_avg_out     (n_avg_out),
        .busy          (busy),
        .missed        (missed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port B: two-cycle read latency.
    logic [31:0] mem [16];
    logic [31:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (bram_en) rd_p1 <= mem[bram_addr[5:2]];
        rd_p2 <= rd_p1;
    end
    assign bram_rdata = rd_p2;

    // Stream monitor.
    logic [31:0] q_dat [$];
    bit          q_last [$];
    int          q_cyc [$];
    int          stall_viol = 0;
    int          fifo_max   = 0;
    int          fall_cyc   = -1;
    bit          prev_stall = 0;
    logic [31:0] prev_dat   = '0;
    logic        prev_last  = 1'b0;
    logic        busy_prev  = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            q_dat.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            q_cyc.push_back(cyc);
        end
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_dat ||
                           m_axis_tlast !== prev_last)) stall_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_dat   = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (int'(dut.fifo_cnt) > fifo_max) fifo_max = int'(dut.fifo_cnt);
        if (busy_prev && !busy) fall_cyc = cyc;
        busy_prev = busy;
    end

    // Random backpressure, applied away from the main driver's time slot.
    bit rnd_en = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_en) m_axis_tready = ($urandom_range(0, 99) < 30);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int i);
`ifdef AVERAGER_READER_SHIFT_EN
        return 32'(i - 5);
`else
        return 32'(i - 8);
`endif
    endfunction

    task automatic clear_q();
        q_dat.delete();
        q_last.delete();
        q_cyc.delete();
        fall_cyc = -1;
    endtask

    task automatic pulse_ready(output int t);
        ready = 1'b1;
        t = cyc;
        step();
        ready = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (q_dat.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic check_frame(input string tag);
        int derr = 0;
        int lerr = 0;
        check_eq({tag, "_beats"}, 64'(q_dat.size()), 64'd16);
        for (int i = 0; i < q_dat.size() && i < 16; i++) begin
            if (q_dat[i] !== exp_word(i)) derr++;
            if (q_last[i] !== (i == 15)) lerr++;
        end
        check_eq({tag, "_data_err"}, 64'(derr), 64'd0);
        check_eq({tag, "_last_err"}, 64'(lerr), 64'd0);
    endtask

    function automatic int first_cyc();
        return (q_cyc.size() > 0) ? q_cyc[0] : -1;
    endfunction

    function automatic int last_cyc();
        return (q_cyc.size() > 15) ? q_cyc[15] : -1;
    endfunction

    initial begin
        int t;
        int nlast;
        for (int i = 0; i < 16; i++) begin
`ifdef AVERAGER_READER_SHIFT_EN
            mem[i] = 32'(4 * i - 20);
`else
            mem[i] = 32'(i - 8);
`endif
        end
        rst = 1'b1;
        ready = 1'b0;
        n_avg = 28'h0;
        shift = 5'd2;
        m_axis_tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state.
        check_eq("rst_addr",   64'(bram_addr), 64'd0);
        check_eq("rst_en",     64'(bram_en), 64'd0);
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_tlast",  64'(m_axis_tlast), 64'd0);
        check_eq("rst_tdata",  64'(m_axis_tdata), 64'd0);
        check_eq("rst_navg",   64'(n_avg_out), 64'd0);
        check_eq("rst_busy",   64'(busy), 64'd0);
        check_eq("rst_missed", 64'(missed), 64'd0);

        // Frame A: tready held high.
        clear_q();
        n_avg = 28'h123;
        pulse_ready(t);
        check_eq("a_busy_t1", 64'(busy), 64'd1);
        check_eq("a_en_t1",   64'(bram_en), 64'd1);
        check_eq("a_addr_t1", 64'(bram_addr), 64'd0);
        wait_beats(16, 100);
        step();
        check_frame("a");
        check_eq("a_first_cyc", 64'(first_cyc()), 64'(t + FIRST));
        check_eq("a_last_cyc",  64'(last_cyc()), 64'(t + FIRST + 15));
        check_eq("a_busy_fall", 64'(fall_cyc), 64'(t + FIRST + 16));
        check_eq("a_navg",      64'(n_avg_out), 64'h123);
        check_eq("a_missed",    64'(missed), 64'd0);

        // Frame B: a 5-cycle stall delays the frame by exactly 5 cycles.
        clear_q();
        pulse_ready(t);
        for (int k = 0; k < 50 && cyc < t + 6; k++) step();
        m_axis_tready = 1'b0;
        repeat (5) step();
        m_axis_tready = 1'b1;
        wait_beats(16, 100);
        step();
        check_frame("b");
        check_eq("b_last_cyc",  64'(last_cyc()), 64'(t + FIRST + 15 + 5));
        check_eq("b_busy_fall", 64'(fall_cyc), 64'(t + FIRST + 16 + 5));

        // Frame C: random backpressure at 30% tready duty.
        clear_q();
        rnd_en = 1;
        pulse_ready(t);
        wait_beats(16, 1000);
        rnd_en = 0;
        m_axis_tready = 1'b1;
        repeat (4) step();
        check_frame("c");
        check_eq("c_busy_end", 64'(busy), 64'd0);

        // Frame D: triggers during readout are counted, not honoured.
        clear_q();
        n_avg = 28'hABCDEF;
        pulse_ready(t);
        n_avg = 28'h5555555;
        wait_beats(5, 100);
        pulse_ready(t);
        wait_beats(10, 100);
        pulse_ready(t);
        check_eq("d_missed_mid", 64'(missed), 64'd2);
        check_eq("d_navg_mid",   64'(n_avg_out), 64'hABCDEF);
        wait_beats(16, 100);
        repeat (4) step();
        check_frame("d");
        check_eq("d_missed_end", 64'(missed), 64'd2);
        check_eq("d_busy_end",   64'(busy), 64'd0);

        // Frame E: reset mid-frame aborts, then a clean frame follows.
        clear_q();
        pulse_ready(t);
        wait_beats(7, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("e_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("e_busy",   64'(busy), 64'd0);
        check_eq("e_missed", 64'(missed), 64'd0);
        check_eq("e_en",     64'(bram_en), 64'd0);
        check_eq("e_navg",   64'(n_avg_out), 64'd0);
        repeat (5) step();
        check_eq("e_discard_tvalid", 64'(m_axis_tvalid), 64'd0);
        nlast = 0;
        foreach (q_last[i]) if (q_last[i]) nlast++;
        check_eq("e_abort_no_tlast", 64'(nlast), 64'd0);
        clear_q();
        pulse_ready(t);
        wait_beats(16, 100);
        step();
        check_frame("e_refill");
        check_eq("e_first_cyc", 64'(first_cyc()), 64'(t + FIRST));

        // Frame F: ready held high for 40 cycles gives exactly one frame.
        clear_q();
        ready = 1'b1;
        repeat (40) step();
        ready = 1'b0;
        repeat (20) step();
        check_frame("f");
        check_eq("f_missed", 64'(missed), 64'd0);
        check_eq("f_busy",   64'(busy), 64'd0);

        // Whole-run stream properties.
        check_eq("stall_stable", 64'(stall_viol), 64'd0);
        check_eq("fifo_no_overflow", 64'(fifo_max <= DEPTH), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
